// File: rtl/mc_control_fsm.sv
// Multicycle CPU control unit.
// This unit sequences fetch/decode/execute/memory/writeback and drives the datapath
// enables and mux selects. Memory accesses use a req/ready handshake with bounded
// wait states, and a sticky fault is raised when an access times out. Branches are
// resolved against the PSR, and a counter tracks retired instructions.
module mc_control_fsm #(
    parameter int WIDTH    = 16,
    parameter int PSRL     = 5,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic [3:0]       op_ext,
    input  logic [3:0]       branch_cond,
    input  logic [PSRL-1:0]  psr,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_en,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             reg_wr,
    output logic [1:0]       wd_sel,
    output logic             alu_b_imm,
    output logic             se_sign,
    output logic             psr_en,
    output logic             fault,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    // Reject parameter values the op-field layout and wait counter cannot support.
    if (WIDTH < 16 || PSRL < 5 || WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_param_check
        $error("mc_control_fsm: unsupported parameter value");
    end

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        WB_LUI,
        MEM_LD,
        MEM_ST,
        BRANCH,
        FAULT
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;

    // Registered per-instruction controls, loaded on entry to the state using them
    logic       reg_wr_q;
    logic [1:0] wd_sel_q;
    logic       psr_en_q;
    logic       alu_b_imm_q;
    logic       se_sign_q;
    logic       pc_en_q;
    logic [1:0] pc_src_q;

    // Decode helpers
    logic [3:0] alu_code;
    logic       r_form;
    logic       i_form;
    logic       is_cmp;
    logic       upd_flags;
    logic       zero_ext;
    logic       is_jcond;
    logic       taken;
    logic       in_fetch;
    logic       in_ld;
    logic       in_st;

    logic flag_n, flag_z, flag_f, flag_l, flag_c;
    assign flag_n = psr[4];
    assign flag_z = psr[3];
    assign flag_f = psr[2];
    assign flag_l = psr[1];
    assign flag_c = psr[0];

    function automatic logic is_alu_op(input logic [3:0] c);
        case (c)
            4'b0101, 4'b1001, 4'b1011, 4'b0001,
            4'b0010, 4'b0011, 4'b1101: is_alu_op = 1'b1;
            default:                   is_alu_op = 1'b0;
        endcase
    endfunction

    // Classify the current instruction and evaluate the branch condition
    always_comb begin
        alu_code  = (op == 4'b0000) ? op_ext : op;
        r_form    = (op == 4'b0000) && is_alu_op(op_ext);
        i_form    = (op != 4'b0000) && is_alu_op(op);
        is_cmp    = (alu_code == 4'b1011);
        upd_flags = (alu_code == 4'b0101) || (alu_code == 4'b1001) || (alu_code == 4'b1011);
        zero_ext  = (alu_code == 4'b0001) || (alu_code == 4'b0010) || (alu_code == 4'b0011);
        is_jcond  = (op == 4'b0100) && (op_ext == 4'b1100);
        taken     = 1'b0;
        case (branch_cond)
            4'b0000: taken = flag_z;
            4'b0001: taken = !flag_z;
            4'b0010: taken = flag_c;
            4'b0011: taken = !flag_c;
            4'b0100: taken = flag_l;
            4'b0101: taken = !flag_l;
            4'b0110: taken = flag_n;
            4'b0111: taken = !flag_n;
            4'b1000: taken = flag_f;
            4'b1001: taken = !flag_f;
            4'b1010: taken = !flag_l && !flag_z;
            4'b1011: taken = flag_l || flag_z;
            4'b1100: taken = !flag_n && !flag_z;
            4'b1101: taken = flag_n || flag_z;
            4'b1110: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // Memory-state decode. FETCH is the reset state, so its request is masked
    // while reset is held to keep every strobe low during reset.
    assign in_fetch = (state == FETCH) && !reset;
    assign in_ld    = (state == MEM_LD);
    assign in_st    = (state == MEM_ST);

    // Strobes that complete a handshake are qualified by mem_ready in the same cycle
    assign mem_req   = in_fetch || in_ld || in_st;
    assign mem_we    = in_st;
    assign addr_sel  = in_ld || in_st;
    assign ir_en     = in_fetch && mem_ready;
    assign pc_en     = pc_en_q || (in_fetch && mem_ready);
    assign pc_src    = pc_src_q;
    assign reg_wr    = reg_wr_q || (in_ld && mem_ready);
    assign wd_sel    = (in_ld && mem_ready) ? 2'b01 : wd_sel_q;
    assign psr_en    = psr_en_q;
    assign alu_b_imm = alu_b_imm_q;
    assign se_sign   = se_sign_q;

    // State sequencing, wait-state timeout, registered controls and retire count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            wait_cnt    <= '0;
            retired     <= '0;
            fault       <= 1'b0;
            illegal     <= 1'b0;
            reg_wr_q    <= 1'b0;
            wd_sel_q    <= 2'b00;
            psr_en_q    <= 1'b0;
            alu_b_imm_q <= 1'b0;
            se_sign_q   <= 1'b0;
            pc_en_q     <= 1'b0;
            pc_src_q    <= 2'b00;
        end else begin
            illegal     <= 1'b0;
            reg_wr_q    <= 1'b0;
            wd_sel_q    <= 2'b00;
            psr_en_q    <= 1'b0;
            alu_b_imm_q <= 1'b0;
            se_sign_q   <= 1'b0;
            pc_en_q     <= 1'b0;
            pc_src_q    <= 2'b00;
            case (state)
                FETCH, MEM_LD, MEM_ST: begin
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        if (state == FETCH) begin
                            state <= DECODE;
                        end else begin
                            state   <= FETCH;
                            retired <= retired + CNT_W'(1);
                        end
                    end else if (wait_cnt == WAIT_LIM) begin
                        wait_cnt <= '0;
                        state    <= FAULT;
                        fault    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DECODE: begin
                    if (r_form || i_form) begin
                        state       <= r_form ? EXEC_R : EXEC_I;
                        reg_wr_q    <= !is_cmp;
                        psr_en_q    <= upd_flags;
                        alu_b_imm_q <= i_form;
                        se_sign_q   <= i_form && !zero_ext;
                    end else if (op == 4'b1111) begin
                        state    <= WB_LUI;
                        reg_wr_q <= 1'b1;
                        wd_sel_q <= 2'b10;
                    end else if (op == 4'b0100 && op_ext == 4'b0000) begin
                        state <= MEM_LD;
                    end else if (op == 4'b0100 && op_ext == 4'b0100) begin
                        state <= MEM_ST;
                    end else if (is_jcond || op == 4'b1100) begin
                        state    <= BRANCH;
                        pc_en_q  <= taken;
                        pc_src_q <= !taken ? 2'b00 : (is_jcond ? 2'b10 : 2'b01);
                    end else begin
                        state   <= FETCH;
                        illegal <= 1'b1;
                        retired <= retired + CNT_W'(1);
                    end
                end
                EXEC_R, EXEC_I, WB_LUI, BRANCH: begin
                    state   <= FETCH;
                    retired <= retired + CNT_W'(1);
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed testbench for mc_control_fsm.
// A second instance with a 4-bit retire counter shares the same stimulus so
// that counter wrap-around can be checked.
module tb_mc_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op, op_ext, branch_cond;
    logic [4:0]  psr;
    logic        mem_ready;

    logic        mem_req, mem_we, addr_sel, ir_en, pc_en, reg_wr;
    logic        alu_b_imm, se_sign, psr_en, fault, illegal;
    logic [1:0]  pc_src, wd_sel;
    logic [31:0] retired;

    logic        mem_req4, mem_we4, addr_sel4, ir_en4, pc_en4, reg_wr4;
    logic        alu_b_imm4, se_sign4, psr_en4, fault4, illegal4;
    logic [1:0]  pc_src4, wd_sel4;
    logic [3:0]  retired4;

    int n_checks = 0;
    int n_errors = 0;
    int exp_ret  = 0;

    always #5 clk = ~clk;

    mc_control_fsm #(.WIDTH(16), .PSRL(5), .WAIT_MAX(15), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .op_ext(op_ext), .branch_cond(branch_cond),
        .psr(psr), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_en(ir_en), .pc_en(pc_en), .pc_src(pc_src),
        .reg_wr(reg_wr), .wd_sel(wd_sel), .alu_b_imm(alu_b_imm), .se_sign(se_sign),
        .psr_en(psr_en), .fault(fault), .illegal(illegal), .retired(retired)
    );

    mc_control_fsm #(.WIDTH(16), .PSRL(5), .WAIT_MAX(15), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .op(op), .op_ext(op_ext), .branch_cond(branch_cond),
        .psr(psr), .mem_ready(mem_ready), .mem_req(mem_req4), .mem_we(mem_we4),
        .addr_sel(addr_sel4), .ir_en(ir_en4), .pc_en(pc_en4), .pc_src(pc_src4),
        .reg_wr(reg_wr4), .wd_sel(wd_sel4), .alu_b_imm(alu_b_imm4), .se_sign(se_sign4),
        .psr_en(psr_en4), .fault(fault4), .illegal(illegal4), .retired(retired4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // From a FETCH cycle: fetch with ready, decode, land in the following state
    task automatic do_instr(input logic [3:0] o, input logic [3:0] e,
                            input logic [3:0] b, input logic [4:0] p);
        op = o; op_ext = e; branch_cond = b; psr = p; mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        cyc();
        #1;
    endtask

    // Step into FETCH after a one-cycle final state and check the retire count
    task automatic finish_instr(input string tag);
        cyc();
        exp_ret++;
        #1;
        check({tag, "_ret"}, retired, exp_ret);
        check({tag, "_ret4"}, {28'd0, retired4}, exp_ret & 32'hF);
    endtask

    initial begin
        reset = 1'b1; op = '0; op_ext = '0; branch_cond = '0; psr = '0; mem_ready = 1'b0;
        cyc();
        cyc();
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_ir_en", ir_en, 0);
        check("rst_pc_en", pc_en, 0);
        check("rst_pc_src", pc_src, 0);
        check("rst_wd_sel", wd_sel, 0);
        check("rst_addr_sel", addr_sel, 0);
        check("rst_fault", fault, 0);
        check("rst_retired", retired, 0);

        // ADD register form: FETCH, DECODE, EXEC_R
        reset = 1'b0; op = 4'h0; op_ext = 4'h5; mem_ready = 1'b1;
        #1;
        check("add_fetch_req", mem_req, 1);
        check("add_fetch_ir_en", ir_en, 1);
        check("add_fetch_pc_en", pc_en, 1);
        check("add_fetch_pc_src", pc_src, 0);
        cyc();
        mem_ready = 1'b0;
        #1;
        check("add_dec_req", mem_req, 0);
        check("add_dec_reg_wr", reg_wr, 0);
        cyc();
        #1;
        check("add_ex_reg_wr", reg_wr, 1);
        check("add_ex_psr_en", psr_en, 1);
        check("add_ex_b_imm", alu_b_imm, 0);
        check("add_ex_ret", retired, 0);
        finish_instr("add");
        check("add_back_req", mem_req, 1);

        // LOAD with three wait cycles
        op = 4'h4; op_ext = 4'h0; mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            mem_ready = (i == 3);
            #1;
            check("ld_req", mem_req, 1);
            check("ld_addr_sel", addr_sel, 1);
            check("ld_we", mem_we, 0);
            check("ld_reg_wr", reg_wr, (i == 3) ? 1 : 0);
            check("ld_wd_sel", wd_sel, (i == 3) ? 1 : 0);
        end
        finish_instr("ld");
        check("ld_fault", fault, 0);

        // Branches
        do_instr(4'hC, 4'h0, 4'h0, 5'b01000);
        check("beq_t_pc_en", pc_en, 1);
        check("beq_t_pc_src", pc_src, 1);
        finish_instr("beq_t");
        do_instr(4'hC, 4'h0, 4'h0, 5'b00000);
        check("beq_n_pc_en", pc_en, 0);
        check("beq_n_pc_src", pc_src, 0);
        finish_instr("beq_n");
        do_instr(4'h4, 4'hC, 4'hE, 5'b00000);
        check("juc_pc_en", pc_en, 1);
        check("juc_pc_src", pc_src, 2);
        finish_instr("juc");
        do_instr(4'hC, 4'h0, 4'hC, 5'b10000);
        check("blt_n_pc_en", pc_en, 0);
        finish_instr("blt_n");
        do_instr(4'hC, 4'h0, 4'hB, 5'b00010);
        check("bhs_t_pc_en", pc_en, 1);
        check("bhs_t_pc_src", pc_src, 1);
        finish_instr("bhs_t");

        // Immediate forms, LUI, store
        do_instr(4'h1, 4'h0, 4'h0, 5'b00000);
        check("andi_b_imm", alu_b_imm, 1);
        check("andi_se", se_sign, 0);
        check("andi_reg_wr", reg_wr, 1);
        check("andi_psr_en", psr_en, 0);
        finish_instr("andi");
        do_instr(4'hB, 4'h0, 4'h0, 5'b00000);
        check("cmpi_reg_wr", reg_wr, 0);
        check("cmpi_psr_en", psr_en, 1);
        check("cmpi_se", se_sign, 1);
        finish_instr("cmpi");
        do_instr(4'hF, 4'h0, 4'h0, 5'b00000);
        check("lui_reg_wr", reg_wr, 1);
        check("lui_wd_sel", wd_sel, 2);
        finish_instr("lui");
        do_instr(4'h4, 4'h4, 4'h0, 5'b00000);
        check("st_req", mem_req, 1);
        check("st_we", mem_we, 1);
        check("st_addr_sel", addr_sel, 1);
        check("st_reg_wr", reg_wr, 0);
        mem_ready = 1'b1;
        finish_instr("st");

        // Undefined opcode
        do_instr(4'h6, 4'h0, 4'h0, 5'b00000);
        exp_ret++;
        check("ill_pulse", illegal, 1);
        check("ill_reg_wr", reg_wr, 0);
        check("ill_fetch", mem_req, 1);
        check("ill_ret", retired, exp_ret);
        cyc();
        #1;
        check("ill_clear", illegal, 0);

        // Retire until the 4-bit counter wraps
        while (exp_ret < 16) begin
            do_instr(4'h0, 4'h5, 4'h0, 5'b00000);
            finish_instr("wrap");
        end
        check("wrap_ret4_zero", {28'd0, retired4}, 0);
        check("wrap_ret16", retired, 16);

        // Ready on the cycle the counter reaches the limit: no fault
        mem_ready = 1'b0;
        repeat (15) cyc();
        op = 4'h0; op_ext = 4'h5; mem_ready = 1'b1;
        #1;
        check("edge_ir_en", ir_en, 1);
        check("edge_fault_pre", fault, 0);
        cyc();
        mem_ready = 1'b0;
        #1;
        check("edge_fault_post", fault, 0);
        check("edge_dec_req", mem_req, 0);
        cyc();
        finish_instr("edge");

        // Timeout in FETCH
        mem_ready = 1'b0;
        repeat (15) cyc();
        #1;
        check("to_fault_pre", fault, 0);
        check("to_req_pre", mem_req, 1);
        cyc();
        #1;
        check("to_fault", fault, 1);
        check("to_req", mem_req, 0);
        check("to_ir_en", ir_en, 0);
        check("to_pc_en", pc_en, 0);
        check("to_reg_wr", reg_wr, 0);
        mem_ready = 1'b1;
        #1;
        check("to_ready_ign", ir_en, 0);
        cyc();
        #1;
        check("to_sticky", fault, 1);
        reset = 1'b1;
        #1;
        check("to_rst_fault", fault, 0);
        check("to_rst_ret", retired, 0);
        check("to_rst_ret4", {28'd0, retired4}, 0);
        check("to_rst_req", mem_req, 0);
        cyc();
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        check("to_rel_req", mem_req, 1);

        // Reset during a completing load drops the write at once
        op = 4'h4; op_ext = 4'h0; mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        cyc();
        mem_ready = 1'b1;
        #1;
        check("mid_reg_wr", reg_wr, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_reg_wr", reg_wr, 0);
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_wd_sel", wd_sel, 0);
        cyc();
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
